bloon_bg_scroller: RTL
======================

BLOON_BG_SCROLLER -- requirements
Module: bloon_bg_scroller

Interface
REQ-001 SHALL have parameter SRC_W, default 320, meaning source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 240, meaning source image height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, default 1, meaning the screen-to-source downscale is 2^SCALE_SHIFT per axis.
REQ-004 SHALL have parameter IDX_W, default 4, meaning palette index width.
REQ-005 SHALL have port vga_clk, input, 1 bit: the only clock.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports DrawX and DrawY, input, 10 bits each: current screen pixel.
REQ-008 SHALL have port blank, input, 1 bit: high means the display is active.
REQ-009 SHALL have ports scroll_x and scroll_y, input, 9 bits each: requested source offset.
REQ-010 SHALL have port scroll_wr, input, 1 bit: single-cycle strobe that writes the scroll request.
REQ-011 SHALL have port scroll_pending, output, 1 bit: a request is waiting for the next frame.
REQ-012 SHALL have port rom_address, output, $clog2(SRC_W*SRC_H) bits: synchronous ROM address.
REQ-013 SHALL have port rom_q, input, IDX_W bits: ROM data, valid 1 cycle after the address.
REQ-014 SHALL have ports red, green and blue, output, 4 bits each: pixel colour.

Function
REQ-015 SHALL compute sx = ((DrawX >> SCALE_SHIFT) + act_x) mod SRC_W and sy = ((DrawY >> SCALE_SHIFT) + act_y) mod SRC_H.
REQ-016 SHALL implement each wrap as a single conditional subtract, because both operands are below the modulus.
REQ-017 SHALL register rom_address = sy*SRC_W + sx (pipeline stage 1).
REQ-018 SHALL have the ROM return rom_q in stage 2.
REQ-019 SHALL register the palette lookup into red/green/blue in stage 3.
REQ-020 SHALL have a total latency of 3 cycles from DrawX/DrawY to RGB.
REQ-021 SHALL delay blank through a 3-stage shift register; when the delayed blank is 0, RGB SHALL be 0 in that cycle.
REQ-022 SHALL load scroll_x/scroll_y into pending registers on scroll_wr and set scroll_pending.
REQ-023 SHALL ignore a scroll_wr with scroll_x >= SRC_W or scroll_y >= SRC_H; pending registers and scroll_pending stay unchanged.
REQ-024 SHALL define frame start as the cycle where DrawX==0 and DrawY==0.
REQ-025 SHALL copy the pending registers into act_x/act_y at frame start when scroll_pending is 1, then clear scroll_pending.
REQ-026 SHALL, when a valid scroll_wr coincides with frame start, load the new value directly into act_x/act_y and leave scroll_pending at 0.
REQ-027 SHALL let a later scroll_wr in the same frame overwrite pending values (last write wins).
REQ-028 SHALL keep act_x/act_y constant for a whole frame.

Reset
REQ-029 SHALL, on Reset, clear act_x, act_y, the pending registers, scroll_pending, rom_address, the blank pipeline and red/green/blue to 0.
REQ-030 SHALL make Reset asserted mid-frame discard any pending scroll request.
REQ-031 SHALL output RGB 0 for the first 3 cycles after Reset deasserts.

Configuration
REQ-032 SHALL, with BLOON_BG_FADE_EN defined, add input fade (2 bits), latched at frame start like scroll.
REQ-033 SHALL, with BLOON_BG_FADE_EN defined, compute each channel as max(palette - 4*fade, 0), saturating and registered in stage 3 with no added latency.
REQ-034 SHALL, without BLOON_BG_FADE_EN, have no fade port and output palette colours unmodified.

Structure
REQ-035 SHALL place the stage-count constant (BG_PIPE_LAT=3), the rgb4 struct typedef and the colour-channel width in shared package bloon_bg_pkg.
REQ-036 SHALL place the index-to-RGB lookup in a registered sub-module bloon_bg_palette_reg.
REQ-037 SHALL keep the ROM external to the block.

Verification
REQ-038 SHALL cover: scroll 0/0, DrawX=5, DrawY=3 -> rom_address=1*320+2=322 one cycle later; RGB=palette(rom_q) 3 cycles after the input.
REQ-039 SHALL cover: scroll_x=300 written mid-frame, DrawX=100 in the next frame -> sx=(50+300)-320=30; the current frame still uses the old offset.
REQ-040 SHALL cover: scroll_wr with scroll_y=240 -> ignored, scroll_pending stays 0.
REQ-041 SHALL cover: scroll_wr at the DrawX=0/DrawY=0 cycle -> act updated immediately, scroll_pending=0.
REQ-042 SHALL cover: blank low for DrawX>=640 -> RGB=0 exactly 3 cycles later, with no stale pixel at the edge.
REQ-043 SHALL cover: Reset asserted with scroll_pending=1 -> pending cleared, act=0, RGB=0 for 3 cycles after release.
REQ-044 SHALL cover (BLOON_BG_FADE_EN): fade=3 with palette red=9 -> red=0; fade=1 -> red=5.

Source files
------------

// File: rtl/bloon_bg_pkg.sv
// Shared constants, colour types and colour helpers for the Bloon background scroller.
package bloon_bg_pkg;

  localparam int BG_PIPE_LAT = 3;
  localparam int BG_CH_W     = 4;

  typedef struct packed {
    logic [BG_CH_W-1:0] r;
    logic [BG_CH_W-1:0] g;
    logic [BG_CH_W-1:0] b;
  } rgb4_t;

  // Fixed 16-colour background palette, packed as 12'hRGB.
  function automatic rgb4_t bg_palette(input logic [3:0] idx);
    rgb4_t c;
    case (idx)
      4'h0:    c = rgb4_t'(12'h000);
      4'h1:    c = rgb4_t'(12'hFFF);
      4'h2:    c = rgb4_t'(12'h931);
      4'h3:    c = rgb4_t'(12'h28F);
      4'h4:    c = rgb4_t'(12'h5A2);
      4'h5:    c = rgb4_t'(12'hC47);
      4'h6:    c = rgb4_t'(12'h777);
      4'h7:    c = rgb4_t'(12'hF80);
      4'h8:    c = rgb4_t'(12'h0C5);
      4'h9:    c = rgb4_t'(12'h39E);
      4'hA:    c = rgb4_t'(12'hE2B);
      4'hB:    c = rgb4_t'(12'h6D1);
      4'hC:    c = rgb4_t'(12'hB5C);
      4'hD:    c = rgb4_t'(12'h4F9);
      4'hE:    c = rgb4_t'(12'h8E3);
      default: c = rgb4_t'(12'hD06);
    endcase
    return c;
  endfunction

  // Darken one channel by 4*fade, clamping at black.
  function automatic logic [BG_CH_W-1:0] bg_fade_ch(input logic [BG_CH_W-1:0] c,
                                                     input logic [1:0] fade);
    logic [BG_CH_W-1:0] dim;
    dim = {fade, 2'b00};
    return (c > dim) ? (c - dim) : '0;
  endfunction

endpackage

// File: rtl/bloon_bg_palette_reg.sv
// Registered index-to-RGB lookup (pipeline stage 3); BLOON_BG_FADE_EN adds saturating fade.
module bloon_bg_palette_reg
  import bloon_bg_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
`ifdef BLOON_BG_FADE_EN
  input  logic [1:0]       fade_i,
`endif
  output rgb4_t            rgb_o
);

  rgb4_t rgb_d;
  rgb4_t rgb_q;

  always_comb begin
    rgb_d = bg_palette(4'(idx_i));
`ifdef BLOON_BG_FADE_EN
    rgb_d.r = bg_fade_ch(rgb_d.r, fade_i);
    rgb_d.g = bg_fade_ch(rgb_d.g, fade_i);
    rgb_d.b = bg_fade_ch(rgb_d.b, fade_i);
`else
    rgb_d = rgb_d;
`endif
  end

  // NOTE: the palette is a constant function, not a RAM, so only the output register needs reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/bloon_bg_scroller.sv
// Wrapping background scroller: screen pixel -> source ROM address -> palette RGB, 3-cycle pipe.
// Optional BLOON_BG_FADE_EN adds a per-frame 2-bit fade input.
module bloon_bg_scroller
  import bloon_bg_pkg::*;
#(
  parameter int SRC_W       = 320,
  parameter int SRC_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int IDX_W       = 4
) (
  input  logic                           vga_clk,
  input  logic                           Reset,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic                           blank,
  input  logic [8:0]                     scroll_x,
  input  logic [8:0]                     scroll_y,
  input  logic                           scroll_wr,
`ifdef BLOON_BG_FADE_EN
  input  logic [1:0]                     fade,
`endif
  output logic                           scroll_pending,
  output logic [$clog2(SRC_W*SRC_H)-1:0] rom_address,
  input  logic [IDX_W-1:0]               rom_q,
  output logic [BG_CH_W-1:0]             red,
  output logic [BG_CH_W-1:0]             green,
  output logic [BG_CH_W-1:0]             blue
);

  localparam int AW = $clog2(SRC_W*SRC_H);

  logic                   frame_start, wr_ok;
  logic [8:0]             act_x_q, act_x_d, act_y_q, act_y_d;
  logic [8:0]             pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic                   pending_q, pending_d;
  logic [10:0]            x_sum, y_sum, sx, sy;
  logic [AW-1:0]          rom_address_q, rom_address_d;
  logic [BG_PIPE_LAT-1:0] blank_q;
  rgb4_t                  pal_rgb;
`ifdef BLOON_BG_FADE_EN
  logic [1:0]             fade_q, fade_d, fade_s1_q, fade_s2_q;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    pending_d = pending_q;
    frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    wr_ok = scroll_wr && (int'(scroll_x) < SRC_W) && (int'(scroll_y) < SRC_H);
    // The frame-start pixel already sees the new offset, so it holds for the whole frame.
    if (frame_start) begin
      if (wr_ok) begin
        act_x_d = scroll_x;
        act_y_d = scroll_y;
      end else if (pending_q) begin
        act_x_d = pend_x_q;
        act_y_d = pend_y_q;
      end
      pending_d = 1'b0;
    end else if (wr_ok) begin
      pend_x_d  = scroll_x;
      pend_y_d  = scroll_y;
      pending_d = 1'b1;
    end
`ifdef BLOON_BG_FADE_EN
    fade_d = frame_start ? fade : fade_q;
`endif
    // Both addends are below the modulus, so one conditional subtract wraps.
    x_sum = 11'(DrawX >> SCALE_SHIFT) + 11'(act_x_d);
    y_sum = 11'(DrawY >> SCALE_SHIFT) + 11'(act_y_d);
    sx = (int'(x_sum) >= SRC_W) ? (x_sum - 11'(SRC_W)) : x_sum;
    sy = (int'(y_sum) >= SRC_H) ? (y_sum - 11'(SRC_H)) : y_sum;
    rom_address_d = AW'(sy) * AW'(SRC_W) + AW'(sx);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      act_x_q       <= '0;
      act_y_q       <= '0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      pending_q     <= 1'b0;
      rom_address_q <= '0;
      blank_q       <= '0;
`ifdef BLOON_BG_FADE_EN
      fade_q        <= '0;
      fade_s1_q     <= '0;
      fade_s2_q     <= '0;
`endif
    end else begin
      act_x_q       <= act_x_d;
      act_y_q       <= act_y_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      pending_q     <= pending_d;
      rom_address_q <= rom_address_d;
      blank_q       <= {blank_q[BG_PIPE_LAT-2:0], blank};
`ifdef BLOON_BG_FADE_EN
      fade_q        <= fade_d;
      fade_s1_q     <= fade_d;
      fade_s2_q     <= fade_s1_q;
`endif
    end
  end

  bloon_bg_palette_reg #(
    .IDX_W (IDX_W)
  ) u_palette (
    .clk_i  (vga_clk),
    .rst_i  (Reset),
    .idx_i  (rom_q),
`ifdef BLOON_BG_FADE_EN
    .fade_i (fade_s2_q),
`endif
    .rgb_o  (pal_rgb)
  );

  assign rom_address    = rom_address_q;
  assign scroll_pending = pending_q;
  assign red   = blank_q[BG_PIPE_LAT-1] ? pal_rgb.r : '0;
  assign green = blank_q[BG_PIPE_LAT-1] ? pal_rgb.g : '0;
  assign blue  = blank_q[BG_PIPE_LAT-1] ? pal_rgb.b : '0;

endmodule
